led_demux_writer: RTL and testbench

LED_DEMUX_WRITER -- requirements
Module: led_demux_writer

---
 rtl/led_demux_writer.sv | 98 +++++++++
 tb/tb_led_demux_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_demux_writer.sv
// Debounced up/down/center buttons steer a 4-bit address and write one switch bit into a 16-bit LED bank.
// Optional registered readback of the addressed LED when LED_DEMUX_READBACK_EN is defined.
module led_demux_writer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clkFromBoard,
  input  logic        resetButtonActiveHigh,
  input  logic        singleSwitchInput,
  input  logic        upBtn,
  input  logic        downBtn,
  input  logic        centerBtn,
`ifdef LED_DEMUX_READBACK_EN
  output logic        readbackBit,
`endif
  output logic [15:0] ledOutputs,
  output logic [3:0]  selectedAddressOut
);

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order: 0 = up, 1 = down, 2 = center.
  logic [NUM_BTN-1:0] rawBtn;
  logic [NUM_BTN-1:0] syncStage1;
  logic [NUM_BTN-1:0] syncStage2;
  logic [NUM_BTN-1:0] acceptedLevel;
  logic [NUM_BTN-1:0] acceptedPrev;
  logic [NUM_BTN-1:0] pressPulse;
  logic [CNT_W-1:0]   debounceCnt [NUM_BTN];

  logic upPulse;
  logic downPulse;
  logic centerPulse;

  assign rawBtn = {centerBtn, downBtn, upBtn};

  // Synchronize then debounce each button; a level is accepted after DEBOUNCE_CYCLES stable cycles.
  always_ff @(posedge clkFromBoard) begin
    if (resetButtonActiveHigh) begin
      syncStage1    <= '0;
      syncStage2    <= '0;
      acceptedLevel <= '0;
      acceptedPrev  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        debounceCnt[i] <= '0;
      end
    end else begin
      syncStage1   <= rawBtn;
      syncStage2   <= syncStage1;
      acceptedPrev <= acceptedLevel;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (syncStage2[i] == acceptedLevel[i]) begin
          debounceCnt[i] <= '0;
        end else if (debounceCnt[i] == CNT_LAST) begin
          debounceCnt[i]   <= '0;
          acceptedLevel[i] <= syncStage2[i];
        end else begin
          debounceCnt[i] <= debounceCnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // High for the single cycle after the accepted level rises; built from registers only.
  assign pressPulse  = acceptedLevel & ~acceptedPrev;
  assign upPulse     = pressPulse[0];
  assign downPulse   = pressPulse[1];
  assign centerPulse = pressPulse[2];

  // Write uses the address as it stands in the pulse cycle; the address moves on the same edge.
  always_ff @(posedge clkFromBoard) begin
    if (resetButtonActiveHigh) begin
      ledOutputs         <= 16'h0000;
      selectedAddressOut <= 4'h0;
    end else begin
      if (centerPulse) begin
        ledOutputs[selectedAddressOut] <= singleSwitchInput;
      end
      if (upPulse && !downPulse) begin
        selectedAddressOut <= selectedAddressOut + 4'd1;
      end else if (downPulse && !upPulse) begin
        selectedAddressOut <= selectedAddressOut - 4'd1;
      end
    end
  end

`ifdef LED_DEMUX_READBACK_EN
  always_ff @(posedge clkFromBoard) begin
    if (resetButtonActiveHigh) begin
      readbackBit <= 1'b0;
    end else begin
      readbackBit <= ledOutputs[selectedAddressOut];
    end
  end
`endif

endmodule

// File: tb/tb_led_demux_writer.sv
// Directed bench for led_demux_writer with a short debounce window.
module tb_led_demux_writer;

  localparam int unsigned DEB = 4;

  logic        clk;
  logic        rst;
  logic        sw;
  logic        up;
  logic        down;
  logic        center;
  logic [15:0] leds;
  logic [3:0]  addr;
`ifdef LED_DEMUX_READBACK_EN
  logic        readback;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int addrChanges = 0;
  int ledChanges  = 0;
  logic [15:0] prevLeds = '0;
  logic [3:0]  prevAddr = '0;

  led_demux_writer #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clkFromBoard         (clk),
    .resetButtonActiveHigh(rst),
    .singleSwitchInput    (sw),
    .upBtn                (up),
    .downBtn              (down),
    .centerBtn            (center),
`ifdef LED_DEMUX_READBACK_EN
    .readbackBit          (readback),
`endif
    .ledOutputs           (leds),
    .selectedAddressOut   (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output changes as seen on the falling edge.
  always @(negedge clk) begin
    if (addr !== prevAddr) addrChanges++;
    if (leds !== prevLeds) ledChanges++;
    prevAddr = addr;
    prevLeds = leds;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit mask: 0 = up, 1 = down, 2 = center; all selected buttons move together.
  task automatic press(input logic [2:0] which);
    up     = which[0];
    down   = which[1];
    center = which[2];
    tick(12);
    up     = 1'b0;
    down   = 1'b0;
    center = 1'b0;
    tick(12);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    int baseAddr;
    int baseLed;
    logic [15:0] pattern;
    rst = 1'b0; sw = 1'b0; up = 1'b0; down = 1'b0; center = 1'b0;
    tick(1);
    doReset();
    checkValue("reset_leds", 32'(leds), 32'h0000);
    checkValue("reset_addr", 32'(addr), 32'h0);

    // Single clean center write of 1 at address 0.
    sw = 1'b1;
    baseLed = ledChanges;
    press(3'b100);
    checkValue("center_leds", 32'(leds), 32'h0001);
    checkValue("center_addr", 32'(addr), 32'h0);
    checkValue("center_one_write", 32'(ledChanges - baseLed), 32'd1);

    // Sixteen increments wrap back to zero, then a decrement wraps to 15.
    for (int i = 1; i <= 16; i++) begin
      press(3'b001);
      checkValue($sformatf("up_step_%0d", i), 32'(addr), 32'(i % 16));
    end
    press(3'b010);
    checkValue("down_wrap", 32'(addr), 32'hF);
    press(3'b001);
    checkValue("up_wrap_back", 32'(addr), 32'h0);

    // Bouncing up button: 2-cycle runs never satisfy the 4-cycle window.
    baseAddr = addrChanges;
    for (int i = 0; i < 10; i++) begin
      up = ~up;
      tick(2);
    end
    checkValue("bounce_no_step", 32'(addr), 32'h0);
    checkValue("bounce_no_change", 32'(addrChanges - baseAddr), 32'd0);
    up = 1'b1;
    tick(20);
    checkValue("bounce_then_hold", 32'(addr), 32'h1);
    checkValue("bounce_one_step", 32'(addrChanges - baseAddr), 32'd1);
    up = 1'b0;
    tick(12);

    // Simultaneous up and down at address 7 cancel.
    for (int i = 0; i < 6; i++) press(3'b001);
    checkValue("reach_7", 32'(addr), 32'h7);
    press(3'b011);
    checkValue("updown_hold", 32'(addr), 32'h7);

    // Center with up at address 3: write at 3, then move to 4.
    for (int i = 0; i < 4; i++) press(3'b010);
    checkValue("reach_3", 32'(addr), 32'h3);
    sw = 1'b1;
    press(3'b101);
    checkValue("center_up_leds", 32'(leds), 32'h0009);
    checkValue("center_up_addr", 32'(addr), 32'h4);

    // Switch activity alone changes nothing.
    baseLed = ledChanges;
    for (int i = 0; i < 6; i++) begin
      sw = ~sw;
      tick(3);
    end
    checkValue("switch_only_leds", 32'(leds), 32'h0009);
    checkValue("switch_only_changes", 32'(ledChanges - baseLed), 32'd0);

    // Write pattern 16'hA5A5 one bit per address, ending back at address 0.
    doReset();
    pattern = 16'hA5A5;
    for (int i = 0; i < 16; i++) begin
      sw = pattern[i];
      press(3'b100);
      press(3'b001);
    end
    checkValue("pattern_leds", 32'(leds), 32'hA5A5);
    checkValue("pattern_addr", 32'(addr), 32'h0);
`ifdef LED_DEMUX_READBACK_EN
    press(3'b001);
    checkValue("readback_addr1", 32'(readback), 32'h0);
    press(3'b001);
    checkValue("readback_addr2", 32'(readback), 32'h1);
    press(3'b010);
    press(3'b010);
`endif

    // Reset lands with down's debounce counter at 2; no decrement may follow.
    down = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checkValue("midreset_leds", 32'(leds), 32'h0000);
    checkValue("midreset_addr", 32'(addr), 32'h0);
    baseAddr = addrChanges;
    tick(3);
    down = 1'b0;
    tick(20);
    checkValue("midreset_no_dec", 32'(addr), 32'h0);
    checkValue("midreset_no_change", 32'(addrChanges - baseAddr), 32'd0);
`ifdef LED_DEMUX_READBACK_EN
    checkValue("readback_reset", 32'(readback), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
